// File: rtl/mul_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mul_acc_stage
//  Purpose  : Accumulates a frame of 1..16 unsigned multiplier products
//             and presents the frame sum through a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mul_acc_stage #(
    parameter int DW = 16,
    parameter int AW = DW + 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_product,
    input  logic [3:0]    acc_len,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_sum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [4:0]    cnt_q, cnt_d;      // needs to reach 16
    logic [4:0]    len_q, len_d;      // frame length, 1..16
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;

    logic [AW-1:0] product_ext;
    logic [4:0]    len_sample;
    logic [4:0]    cnt_inc;
    logic          xfer;

    assign product_ext = {{(AW-DW){1'b0}}, in_product};
    // A length code of zero encodes the maximum frame of sixteen products.
    assign len_sample  = (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
    assign cnt_inc     = cnt_q + 5'd1;

    // Upstream may push whenever no finished sum is waiting and no clear is active.
    assign in_ready = (state_q != ST_DONE) && !clr;
    assign xfer     = in_valid && in_ready;

    // Next-state, accumulator and counter update; clear overrides everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        acc_d   = product_ext;
                        cnt_d   = 5'd1;
                        len_d   = len_sample;
                        state_d = (len_sample == 5'd1) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (xfer) begin
                        acc_d = acc_q + product_ext;
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output registers track the next state so out_valid rises with the last accept.
    always_comb begin
        out_valid_d = (state_d == ST_DONE);
        out_sum_d   = acc_d;
    end

    // State registers with asynchronous reset discarding any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_acc_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_acc_stage
//  Purpose  : Self-checking bench for mul_acc_stage against a frame-level
//             reference model (running sum, product count, frame length).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_acc_stage;

    localparam int DW = 16;
    localparam int AW = DW + 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_product;
    logic [3:0]    acc_len;
    logic          clr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is a list of accepted products and a length.
    int     m_taken;      // products accepted in the current frame
    int     m_len;        // frame length latched at first product
    longint m_sum;        // arithmetic sum of accepted products
    bit     m_full;       // frame complete, sum waiting for downstream

    always #5 clk = ~clk;

    mul_acc_stage #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .acc_len    (acc_len),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_taken = 0;
        m_len   = 0;
        m_sum   = 0;
        m_full  = 0;
    endtask

    // Apply the frame rules for one rising edge with the current inputs.
    task automatic model_edge();
        if (clr) begin
            m_full  = 0;
            m_taken = 0;
            m_sum   = 0;
        end else if (m_full) begin
            if (out_ready) begin
                m_full  = 0;
                m_taken = 0;
            end
        end else if (in_valid) begin
            if (m_taken == 0) begin
                m_len = (acc_len == 4'd0) ? 16 : int'(acc_len);
                m_sum = longint'(in_product);
            end else begin
                m_sum = m_sum + longint'(in_product);
            end
            m_taken++;
            if (m_taken == m_len) m_full = 1;
        end
    endtask

    // One clock: check outputs mid-cycle, then advance DUT and model together.
    task automatic step();
        logic [AW-1:0] exp_sum;
        @(negedge clk);
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_full && !clr)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        if (m_full) begin
            exp_sum = m_sum[AW-1:0];
            chk("out_sum", {12'd0, out_sum}, {12'd0, exp_sum});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic [DW-1:0] p, input logic [3:0] len);
        in_valid   = 1'b1;
        in_product = p;
        acc_len    = len;
        step();
        in_valid   = 1'b0;
        in_product = DW'($urandom);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        acc_len    = '0;
        clr        = 1'b0;
        out_ready  = 1'b0;
        model_reset();

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {12'd0, out_sum}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Four back-to-back products of 0x47*0x45
        for (int i = 0; i < 4; i++) send(16'h1323, 4'd4);
        chk("t4_latency", {31'd0, out_valid}, 32'd1);
        chk("t4_sum", {12'd0, out_sum}, 32'h04C8C);
        drain();

        // Sixteen maximal products with random gaps
        for (int i = 0; i < 16; i++) begin
            int gaps;
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) step();
            chk("t16_no_early", {31'd0, out_valid}, 32'd0);
            send(16'hFE01, 4'd0);
        end
        chk("t16_sum", {12'd0, out_sum}, 32'hFE010);

        // Backpressure: sum held, input refused, upstream noise ignored
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'($urandom);
            in_product = DW'($urandom);
            step();
            chk("hold_sum", {12'd0, out_sum}, 32'hFE010);
        end
        in_valid = 1'b0;
        drain();
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);

        // Clear mid-frame drops the concurrent product
        send(16'h0100, 4'd3);
        send(16'h0100, 4'd3);
        clr        = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'h0700;
        step();
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0005, 4'd1);
        chk("len1_valid", {31'd0, out_valid}, 32'd1);
        chk("len1_sum", {12'd0, out_sum}, 32'h00005);
        drain();

        // Length sampled once; asynchronous reset while a sum is pending
        send(16'h1111, 4'd2);
        send(16'h2222, 4'd5);
        chk("len_latch_valid", {31'd0, out_valid}, 32'd1);
        chk("len_latch_sum", {12'd0, out_sum}, 32'h03333);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_out_sum", {12'd0, out_sum}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_product = DW'($urandom);
            acc_len    = 4'($urandom);
            out_ready  = 1'($urandom);
            clr        = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_acc_stage.md
MUL_ACC_STAGE -- requirements
Module: mul_acc_stage

Interface
REQ-001 Parameter: DW, 16, width of each incoming product (the 8x8 multiplier output width).
REQ-002 Parameter: AW, DW+4, accumulator/output width (headroom for 16 summands).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  in_product holds a valid product.
REQ-006 Port: in_ready  output  1  block accepts a product this cycle.
REQ-007 Port: in_product  input  DW  unsigned product from the multiplier stage.
REQ-008 Port: acc_len  input  4  products per frame; 1..15 literal, 0 means 16.
REQ-009 Port: clr  input  1  synchronous abort/clear of the current frame.
REQ-010 Port: out_valid  output  1  out_sum holds a completed frame sum.
REQ-011 Port: out_ready  input  1  downstream accepts out_sum.
REQ-012 Port: out_sum  output  AW  unsigned sum of the frame's products.

Function
REQ-013 The block SHALL implement three states: IDLE, ACC, DONE.
REQ-014 A transfer SHALL occur only on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL equal 1 in IDLE and ACC, 0 in DONE, and 0 in any cycle where clr=1.
REQ-016 IDLE transfer: acc loads zero-extended in_product, cnt=1, len_q latches acc_len (0 -> 16); next state DONE if len_q=1, else ACC.
REQ-017 ACC transfer: acc=acc+in_product, cnt=cnt+1; when the incremented cnt equals len_q, next state SHALL be DONE.
REQ-018 acc_len SHALL be sampled only on the first transfer of a frame; later changes SHALL NOT affect the current frame.
REQ-019 Cycles with in_valid=0 in IDLE/ACC SHALL leave acc, cnt and state unchanged (gaps allowed).
REQ-020 Arithmetic SHALL be unsigned, AW bits, with no overflow possible (16 x (2^DW-1) < 2^AW); no saturation logic.
REQ-021 out_valid SHALL be 1 exactly while in DONE; out_sum SHALL be registered and equal acc, stable while out_valid=1 and out_ready=0.
REQ-022 Latency: out_valid SHALL rise on the clock edge that accepts the frame's last product (visible the following cycle).
REQ-023 DONE with out_ready=1 SHALL transition to IDLE with cnt=0 on the next edge; out_valid falls that edge; one-cycle bubble before the next frame accepts.
REQ-024 clr=1 SHALL override all other events: next state IDLE, acc=0, cnt=0, out_valid=0, any concurrent in/out transfer discarded.
REQ-025 out_ready SHALL be ignored outside DONE; in_product SHALL be ignored when no transfer occurs.

Reset
REQ-026 While rst_n=0: state=IDLE, acc=0, cnt=0, len_q=0, out_valid=0, out_sum=0; in_ready SHALL be 1 once rst_n=1 and clr=0.
REQ-027 Reset assertion at any point (including mid-frame or in DONE with a pending sum) SHALL discard all frame data immediately, without waiting for a clock edge.

Verification
REQ-028 acc_len=4, four back-to-back 0x1323 (0x47*0x45) -> out_valid one edge after 4th transfer, out_sum=0x04C8C.
REQ-029 acc_len=0, sixteen 0xFE01 products with random in_valid gaps -> out_sum=0xFE010, no earlier out_valid.
REQ-030 Frame complete, out_ready held 0 for 5 cycles -> out_sum stable, in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-031 acc_len=3, two products 0x0100, then clr=1 with in_valid=1 -> product dropped, acc=0; next frame acc_len=1 with 0x0005 -> out_sum=0x00005.
REQ-032 acc_len=2, change acc_len to 5 after first transfer -> frame ends after 2 products; rst_n pulsed low while in DONE -> out_valid=0 and out_sum=0 asynchronously.
